// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-miss memory arbiter: FSM states,
// requester IDs and the line-offset width helper.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

    function automatic int line_off_w(input int beats, input int data_w);
        return $clog2(beats * data_w / 8);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of mem_arbiter.
// slave = arbiter view, master = caches plus memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_gnt;
    logic              ic_rvalid;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wready;
    logic              dc_gnt;
    logic              dc_rvalid;
    logic              dc_done;
    logic [DATA_W-1:0] rdata;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_cmd_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic              stall;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
        input  mem_wdata_ready,
        output ic_gnt, ic_rvalid, ic_done,
        output dc_gnt, dc_rvalid, dc_done, dc_wready,
        output rdata, mem_cmd_valid, mem_cmd_addr, mem_cmd_we,
        output mem_wdata, mem_wdata_valid, stall
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid,
        output mem_wdata_ready,
        input  ic_gnt, ic_rvalid, ic_done,
        input  dc_gnt, dc_rvalid, dc_done, dc_wready,
        input  rdata, mem_cmd_valid, mem_cmd_addr, mem_cmd_we,
        input  mem_wdata, mem_wdata_valid, stall
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between icache and dcache requests.
// MEM_ARB_RR_EN selects round-robin; default is fixed dcache priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    ic_req,
    input  logic    dc_req,
    input  logic    take,
    output req_id_t win
);

`ifdef MEM_ARB_RR_EN
    req_id_t last_q, last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_IC;
        end else begin
            last_q <= last_d;
        end
    end

    // On contention the side not granted last goes first
    always_comb begin
        win = REQ_DC;
        if (ic_req && dc_req) begin
            if (last_q == REQ_DC) begin
                win = REQ_IC;
            end
        end else if (ic_req) begin
            win = REQ_IC;
        end
        last_d = last_q;
        if (take) begin
            last_d = win;
        end
    end
`else
    logic unused_rr;

    assign unused_rr = clk ^ rst ^ take;

    always_comb begin
        win = REQ_DC;
        if (ic_req && !dc_req) begin
            win = REQ_IC;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache miss arbiter onto one line-burst memory port.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int OFF_W = line_off_w(BEATS, DATA_W);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    state_t            state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           win;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              any_req;
    logic              take;
    logic              rd_beat;
    logic              wr_beat;

    assign any_req = bus.ic_req | bus.dc_req;
    assign take    = (state_q == S_IDLE) && any_req;
    // last_q marks the cycle the final beat is presented; no more beats taken
    assign rd_beat = (state_q == S_RDATA) && bus.mem_rdata_valid && !last_q;
    assign wr_beat = (state_q == S_WDATA) && bus.mem_wdata_ready;

    mem_arb_pick u_pick (
        .clk    (clk),
        .rst    (rst),
        .ic_req (bus.ic_req),
        .dc_req (bus.dc_req),
        .take   (take),
        .win    (win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= REQ_IC;
            addr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_CMD;
            end
            S_CMD: begin
                if (bus.mem_cmd_ready) begin
                    if (we_q) state_d = S_WDATA;
                    else      state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (last_q) state_d = S_DONE;
            end
            S_WDATA: begin
                if (wr_beat && cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        if (take) begin
            owner_d = win;
            if (win == REQ_DC) begin
                addr_d = bus.dc_addr;
                we_d   = bus.dc_we;
            end else begin
                addr_d = bus.ic_addr;
                we_d   = 1'b0;
            end
        end
        if (state_q == S_CMD) begin
            cnt_d = '0;
        end else if (rd_beat || wr_beat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        last_d   = rd_beat && (cnt_q == LAST);
        rvalid_d = rd_beat;
        rdata_d  = rd_beat ? bus.mem_rdata : rdata_q;
    end

    always_comb begin
        bus.ic_gnt          = 1'b0;
        bus.dc_gnt          = 1'b0;
        bus.ic_rvalid       = 1'b0;
        bus.dc_rvalid       = 1'b0;
        bus.ic_done         = 1'b0;
        bus.dc_done         = 1'b0;
        bus.mem_cmd_valid   = (state_q == S_CMD);
        bus.mem_cmd_we      = (state_q == S_CMD) && we_q;
        bus.mem_wdata_valid = (state_q == S_WDATA);
        bus.dc_wready       = wr_beat;
        if (state_q != S_IDLE) begin
            if (owner_q == REQ_DC) begin
                bus.dc_gnt    = 1'b1;
                bus.dc_rvalid = rvalid_q;
                bus.dc_done   = (state_q == S_DONE);
            end else begin
                bus.ic_gnt    = 1'b1;
                bus.ic_rvalid = rvalid_q;
                bus.ic_done   = (state_q == S_DONE);
            end
        end
    end

    assign bus.mem_cmd_addr = addr_q & LINE_MASK;
    assign bus.rdata        = rdata_q;
    assign bus.mem_wdata    = bus.dc_wdata;
    assign bus.stall        = any_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_arbiter;

    localparam logic [1:0] EV_CMD  = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_WR   = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        id;
        logic [31:0] data;
    } ev_t;

    logic clk;
    logic rst;
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_seen = 0;
    int          cyc = 0;
    int          last_beat_cyc = 0;
    int          cmd_wait = 0;
    logic [31:0] rd_base = 0;
    logic [31:0] wb_base = 0;
    int          wb_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [1:0] k, input logic d,
                          input logic [31:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got kind %0d id %0d data %h",
                     k, d, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.id !== d || e.data !== v) begin
                n_bad++;
                $display("FAIL sb_event: got kind %0d id %0d data %h, expected kind %0d id %0d data %h",
                         k, d, v, e.kind, e.id, e.data);
            end
        end
    endtask

    // id is the owner for beats/done and the we flag for commands
    task automatic push_line(input logic dc, input logic [31:0] line,
                             input logic we, input logic [31:0] base,
                             input int nbeats, input logic with_done);
        exp_q.push_back('{EV_CMD, we, line});
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back('{we ? EV_WR : EV_RD, dc, base + 32'(i)});
        end
        if (with_done) exp_q.push_back('{EV_DONE, dc, 32'h0});
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (bus.mem_cmd_valid && bus.mem_cmd_ready)
                    sb_pop(EV_CMD, bus.mem_cmd_we, bus.mem_cmd_addr);
                if (bus.ic_rvalid) begin
                    sb_pop(EV_RD, 1'b0, bus.rdata);
                    rd_seen++;
                    last_beat_cyc = cyc;
                end
                if (bus.dc_rvalid) begin
                    sb_pop(EV_RD, 1'b1, bus.rdata);
                    rd_seen++;
                    last_beat_cyc = cyc;
                end
                if (bus.dc_wready) begin
                    sb_pop(EV_WR, 1'b1, bus.mem_wdata);
                    last_beat_cyc = cyc;
                end
                if (bus.ic_done || bus.dc_done) begin
                    sb_pop(EV_DONE, bus.dc_done, 32'h0);
                    check("done_lag", 64'(cyc - last_beat_cyc), 64'd1);
                end
            end
        end
    end

    // memory model: accepts commands after cmd_wait cycles
    initial begin
        int   phase;
        int   beat;
        logic tog;
        logic acc_we;
        phase = 0; beat = 0; tog = 1'b1; acc_we = 1'b0;
        bus.mem_cmd_ready   = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_wdata_ready = 1'b0;
        bus.mem_rdata       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                phase = 0;
                bus.mem_cmd_ready   = 1'b0;
                bus.mem_rdata_valid = 1'b0;
                bus.mem_wdata_ready = 1'b0;
            end else begin
                if (phase == 0) begin
                    bus.mem_rdata_valid = 1'b0;
                    bus.mem_wdata_ready = 1'b0;
                    if (bus.mem_cmd_ready) begin
                        bus.mem_cmd_ready = 1'b0;
                        phase = acc_we ? 2 : 1;
                        beat = 0;
                        tog = 1'b1;
                    end else if (bus.mem_cmd_valid) begin
                        if (cmd_wait > 0) begin
                            cmd_wait--;
                        end else begin
                            bus.mem_cmd_ready = 1'b1;
                            acc_we = bus.mem_cmd_we;
                        end
                    end
                end
                if (phase == 1) begin
                    if (beat < 8) begin
                        bus.mem_rdata_valid = 1'b1;
                        bus.mem_rdata = rd_base + 32'(beat);
                        beat++;
                    end else begin
                        bus.mem_rdata_valid = 1'b0;
                        phase = 0;
                    end
                end else if (phase == 2) begin
                    if (beat < 8) begin
                        bus.mem_wdata_ready = tog;
                        if (tog) beat++;
                        tog = ~tog;
                    end else begin
                        bus.mem_wdata_ready = 1'b0;
                        phase = 0;
                    end
                end
            end
        end
    end

    // dcache write-back source: advance beat on dc_wready
    initial begin
        logic adv;
        bus.dc_wdata = '0;
        forever begin
            @(negedge clk);
            adv = bus.dc_wready;
            @(posedge clk);
            #1;
            if (adv) wb_idx++;
            bus.dc_wdata = wb_base + 32'(wb_idx);
        end
    end

    task automatic start_req(input logic dc, input logic we,
                             input logic [31:0] addr);
        @(posedge clk);
        #1;
        if (dc) begin
            bus.dc_req  = 1'b1;
            bus.dc_we   = we;
            bus.dc_addr = addr;
        end else begin
            bus.ic_req  = 1'b1;
            bus.ic_addr = addr;
        end
    endtask

    task automatic finish_req(input logic dc, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dc ? bus.dc_done : bus.ic_done) begin
                got = 1'b1;
                break;
            end
        end
        if (got) check({nm, "_gnt_at_done"},
                       64'(dc ? bus.dc_gnt : bus.ic_gnt), 64'd1);
        else check({nm, "_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (dc) bus.dc_req = 1'b0;
        else    bus.ic_req = 1'b0;
    endtask

    task automatic contest(input logic exp_dc, input string nm);
        push_line(exp_dc, exp_dc ? 32'h0000_0080 : 32'h0000_2000,
                  1'b0, rd_base, 8, 1'b1);
        @(posedge clk);
        #1;
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_2004;
        bus.dc_req  = 1'b1;
        bus.dc_we   = 1'b0;
        bus.dc_addr = 32'h0000_0088;
        @(negedge clk);
        @(negedge clk);
        check({nm, "_winner"}, 64'({bus.dc_gnt, bus.ic_gnt}),
              exp_dc ? 64'd2 : 64'd1);
        @(posedge clk);
        #1;
        if (exp_dc) bus.ic_req = 1'b0;
        else        bus.dc_req = 1'b0;
        finish_req(exp_dc, nm);
    endtask

    function automatic logic [9:0] ctl_outs();
        return {bus.ic_gnt, bus.ic_rvalid, bus.ic_done,
                bus.dc_gnt, bus.dc_rvalid, bus.dc_done, bus.dc_wready,
                bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_wdata_valid};
    endfunction

    initial begin
        logic got;
        rst = 1'b0;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0;
        #2;
        check("rst_ctl", 64'(ctl_outs()), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_addr", 64'(bus.mem_cmd_addr), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        rd_base = 32'hD000_0000;
        contest(1'b1, "arb1");
        rd_base = 32'hD100_0000;
`ifdef MEM_ARB_RR_EN
        contest(1'b0, "arb2");
`else
        contest(1'b1, "arb2");
`endif

        // icache fill
        rd_base = 32'hA000_0000;
        push_line(1'b0, 32'h0000_1220, 1'b0, rd_base, 8, 1'b1);
        start_req(1'b0, 1'b0, 32'h0000_1234);
        @(negedge clk);
        check("ic_stall", 64'(bus.stall), 64'd1);
        @(negedge clk);
        check("ic_cyc1", 64'({bus.ic_gnt, bus.mem_cmd_valid}), 64'd3);
        finish_req(1'b0, "ic_fill");

        // dcache write-back, memory ready toggling
        wb_base = 32'hB000_0000;
        wb_idx = 0;
        push_line(1'b1, 32'h0000_0040, 1'b1, wb_base, 8, 1'b1);
        start_req(1'b1, 1'b1, 32'h0000_0040);
        @(negedge clk);
        @(negedge clk);
        check("dc_cyc1",
              64'({bus.dc_gnt, bus.mem_cmd_valid, bus.mem_cmd_we}),
              64'd7);
        finish_req(1'b1, "dc_wb");

        // command back-pressure
        cmd_wait = 5;
        rd_base = 32'hC000_0000;
        push_line(1'b0, 32'h0000_5660, 1'b0, rd_base, 8, 1'b1);
        start_req(1'b0, 1'b0, 32'h0000_5678);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cmd_hold_valid", 64'(bus.mem_cmd_valid), 64'd1);
            check("cmd_hold_addr", 64'(bus.mem_cmd_addr),
                  64'h5660);
            check("cmd_hold_stall", 64'(bus.stall), 64'd1);
        end
        finish_req(1'b0, "cmd_wait");

        // reset during beat 3 of a read
        rd_base = 32'hE000_0000;
        push_line(1'b0, 32'h0000_3000, 1'b0, rd_base, 3, 1'b0);
        rd_seen = 0;
        got = 1'b0;
        start_req(1'b0, 1'b0, 32'h0000_3010);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (rd_seen >= 3) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("abort_timeout", 64'd0, 64'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_ctl", 64'(ctl_outs()), 64'd0);
        check("abort_rdata", 64'(bus.rdata), 64'd0);
        check("abort_addr", 64'(bus.mem_cmd_addr), 64'd0);
        check("abort_stall", 64'(bus.stall), 64'd1);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        bus.ic_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rd_base = 32'hF000_0000;
        push_line(1'b0, 32'h0000_3000, 1'b0, rd_base, 8, 1'b1);
        start_req(1'b0, 1'b0, 32'h0000_3010);
        finish_req(1'b0, "post_rst");

        repeat (3) @(negedge clk);
        check("sb_left", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
